// File: rtl/mac_table_ctrl.sv
// MAC learning table with lookup/learn arbitration, round-robin victim replacement,
// periodic aging sweeps and a full-table flush.
module mac_table_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_BITS    = 4,
  parameter int PORT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_req,
  input  logic [47:0]           lookup_mac,
  output logic                  lookup_ack,
  output logic                  lookup_hit,
  output logic [PORT_WIDTH-1:0] lookup_port,
  input  logic                  learn_req,
  input  logic [47:0]           learn_mac,
  input  logic [PORT_WIDTH-1:0] learn_port,
  output logic                  learn_ack,
  input  logic                  age_tick,
  input  logic                  flush,
  output logic [IDX_BITS:0]     entries_used,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_LEARN, S_AGE, S_FLUSH, S_DONE
  } state_t;

  state_t state_reg, state_next;
  logic   op_learn_reg, op_learn_next;
  logic   last_grant_learn_reg, last_grant_learn_next;
  logic   flush_pend_reg, age_pend_reg;
  logic   start_age, start_flush;

  logic [IDX_BITS-1:0]   age_idx_reg;
  logic [IDX_BITS-1:0]   victim_ptr_reg;
  logic [IDX_BITS:0]     used_reg;
  logic                  hit_reg;
  logic [PORT_WIDTH-1:0] hit_port_reg;

  logic [NUM_ENTRIES-1:0] valid_reg;
  logic [NUM_ENTRIES-1:0] age_reg;
  logic [47:0]            mac_reg  [NUM_ENTRIES];
  logic [PORT_WIDTH-1:0]  port_reg [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] lookup_match, learn_match;
  logic [IDX_BITS-1:0]    lookup_idx, learn_idx, free_idx;
  logic                   grant_learn;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_cmp
      assign lookup_match[gi] = valid_reg[gi] && (mac_reg[gi] == lookup_mac);
      assign learn_match[gi]  = valid_reg[gi] && (mac_reg[gi] == learn_mac);
    end
  endgenerate

  // Scan downwards so the lowest matching / free index is the one left standing.
  always_comb begin
    lookup_idx = '0;
    learn_idx  = '0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (lookup_match[i]) lookup_idx = IDX_BITS'(i);
      if (learn_match[i])  learn_idx  = IDX_BITS'(i);
      if (!valid_reg[i])   free_idx   = IDX_BITS'(i);
    end
  end

  assign grant_learn = (lookup_req && learn_req) ? !last_grant_learn_reg : learn_req;

  always_comb begin
    state_next            = state_reg;
    op_learn_next         = op_learn_reg;
    last_grant_learn_next = last_grant_learn_reg;
    start_age             = 1'b0;
    start_flush           = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (flush_pend_reg) begin
          state_next  = S_FLUSH;
          start_flush = 1'b1;
        end else if (lookup_req || learn_req) begin
          op_learn_next         = grant_learn;
          last_grant_learn_next = grant_learn;
          state_next            = grant_learn ? S_LEARN : S_LOOKUP;
        end else if (age_pend_reg) begin
          state_next = S_AGE;
          start_age  = 1'b1;
        end
      end
      S_LOOKUP, S_LEARN: state_next = S_DONE;
      S_AGE:   if (age_idx_reg == IDX_BITS'(NUM_ENTRIES - 1)) state_next = S_IDLE;
      S_FLUSH: state_next = S_IDLE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg            <= S_IDLE;
      op_learn_reg         <= 1'b0;
      last_grant_learn_reg <= 1'b1;
      flush_pend_reg       <= 1'b0;
      age_pend_reg         <= 1'b0;
    end else begin
      state_reg            <= state_next;
      op_learn_reg         <= op_learn_next;
      last_grant_learn_reg <= last_grant_learn_next;
      // A pulse landing on the serving cycle survives, so it is not lost.
      flush_pend_reg       <= flush || (flush_pend_reg && !start_flush);
      age_pend_reg         <= age_tick || (age_pend_reg && !start_age);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg      <= '0;
      age_reg        <= '0;
      used_reg       <= '0;
      victim_ptr_reg <= '0;
      age_idx_reg    <= '0;
      hit_reg        <= 1'b0;
      hit_port_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: age_idx_reg <= '0;
        S_LOOKUP: begin
          hit_reg      <= |lookup_match;
          hit_port_reg <= (|lookup_match) ? port_reg[lookup_idx] : '0;
        end
        S_LEARN: begin
          if (!learn_mac[40]) begin
            if (|learn_match) begin
              port_reg[learn_idx] <= learn_port;
              age_reg[learn_idx]  <= 1'b1;
            end else if (!(&valid_reg)) begin
              valid_reg[free_idx] <= 1'b1;
              mac_reg[free_idx]   <= learn_mac;
              port_reg[free_idx]  <= learn_port;
              age_reg[free_idx]   <= 1'b1;
              used_reg            <= used_reg + 1'b1;
            end else begin
              mac_reg[victim_ptr_reg]  <= learn_mac;
              port_reg[victim_ptr_reg] <= learn_port;
              age_reg[victim_ptr_reg]  <= 1'b1;
              victim_ptr_reg           <= victim_ptr_reg + 1'b1;
            end
          end
        end
        S_AGE: begin
          if (valid_reg[age_idx_reg]) begin
            if (!age_reg[age_idx_reg]) begin
              valid_reg[age_idx_reg] <= 1'b0;
              used_reg               <= used_reg - 1'b1;
            end else begin
              age_reg[age_idx_reg] <= 1'b0;
            end
          end
          age_idx_reg <= age_idx_reg + 1'b1;
        end
        S_FLUSH: begin
          valid_reg      <= '0;
          used_reg       <= '0;
          victim_ptr_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign lookup_ack   = (state_reg == S_DONE) && !op_learn_reg;
  assign learn_ack    = (state_reg == S_DONE) && op_learn_reg;
  assign lookup_hit   = hit_reg;
  assign lookup_port  = hit_port_reg;
  assign entries_used = used_reg;
  assign busy         = (state_reg != S_IDLE);

endmodule
